car_slot_writer: RTL and testbench

CAR_SLOT_WRITER -- requirements
Module: car_slot_writer

---
 rtl/car_slot_pkg.sv | 41 ++++
 rtl/car_slot_writer_if.sv | 30 +++
 rtl/car_cmd_fifo.sv | 69 ++++++
 rtl/car_slot_writer.sv | 143 ++++++++++++++
 tb/tb_car_slot_writer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/car_slot_pkg.sv
// ---------------------------------------------------------------------------
// car_slot_pkg
// Shared types and helpers for the car slot writer.
//   state_t      : writer FSM states.
//   field_t      : which per-car register is being addressed.
//   car_cmd_t    : one queued car update (index, x, y, ctrl).
//   REG_BANK_BIT : slot address bit that selects the register bank.
//   car_offset() : register offset of car n, field f (x=3n+1, y=3n+2,
//                  ctrl=3n+3); offset 0 is the bypass register.
// ---------------------------------------------------------------------------
package car_slot_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_VB = 3'd1,
        WR_X    = 3'd2,
        WR_Y    = 3'd3,
        WR_CTRL = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FLD_X    = 2'd0,
        FLD_Y    = 2'd1,
        FLD_CTRL = 2'd2
    } field_t;

    typedef struct packed {
        logic [4:0]  idx;
        logic [10:0] x;
        logic [10:0] y;
        logic [3:0]  ctrl;
    } car_cmd_t;

    localparam int REG_BANK_BIT = 13;

    // Only called with in-range indices, so the 6-bit result never wraps.
    function automatic logic [5:0] car_offset(input logic [4:0] n, input field_t f);
        return 6'(n) * 6'd3 + 6'(f) + 6'd1;
    endfunction

endpackage

// File: rtl/car_slot_writer_if.sv
// ---------------------------------------------------------------------------
// car_slot_writer_if
// Groups the command handshake and the video-slot write bus.
//   cmd_valid/cmd_ready     : command handshake
//   cmd_idx/cmd_x/cmd_y/cmd_ctrl : command payload
//   cs/write/addr/wr_data   : video-slot write port
// Modports: slave = the writer, master = the command source / slot observer.
// ---------------------------------------------------------------------------
interface car_slot_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_idx;
    logic [10:0] cmd_x;
    logic [10:0] cmd_y;
    logic [3:0]  cmd_ctrl;
    logic        cs;
    logic        write;
    logic [13:0] addr;
    logic [31:0] wr_data;

    modport slave (
        input  cmd_valid, cmd_idx, cmd_x, cmd_y, cmd_ctrl,
        output cmd_ready, cs, write, addr, wr_data
    );

    modport master (
        output cmd_valid, cmd_idx, cmd_x, cmd_y, cmd_ctrl,
        input  cmd_ready, cs, write, addr, wr_data
    );
endinterface

// File: rtl/car_cmd_fifo.sv
// ---------------------------------------------------------------------------
// car_cmd_fifo
// Synchronous FIFO of car_cmd_t entries.
//   clk, reset_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din    : write request and entry
//   pop          : remove head entry
//   full, empty  : occupancy flags from the registered count
//   head         : oldest entry
//   multi        : at least two entries held
//   second_idx   : car index of the entry behind the head
// A push while full is still accepted when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module car_cmd_fifo
    import car_slot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  car_cmd_t   din,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output car_cmd_t   head,
    output logic       multi,
    output logic [4:0] second_idx
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    car_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW-1:0]   rptr_p1;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rptr_p1 = rptr + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign multi      = (count > (AW+1)'(1));
    assign head       = mem[rptr];
    assign second_idx = mem[rptr_p1].idx;
endmodule

// File: rtl/car_slot_writer.sv
// ---------------------------------------------------------------------------
// car_slot_writer
// Queues car sprite updates and writes each car's x, y and ctrl registers
// into the video slot register bank during vertical blank.
//   clk, reset_n : clock, synchronous active-low reset
//   y            : current line number from the video sync core
//   bus          : command handshake + slot write port (slave modport)
//   busy         : FIFO non-empty or a car update in flight
//   err_idx      : one-cycle pulse when an out-of-range car index is dropped
// Build option: CAR_WR_VBLANK_GATE_EN defined gates writes to lines
// y >= V_ACTIVE; undefined treats vblank as always true and ignores y.
// ---------------------------------------------------------------------------
module car_slot_writer
    import car_slot_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CARS   = 20,
    parameter int V_ACTIVE   = 480
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [10:0]        y,
    car_slot_writer_if.slave   bus,
    output logic               busy,
    output logic               err_idx
);
    state_t      state;
    state_t      state_nxt;
    car_cmd_t    cmd_in;
    car_cmd_t    head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_multi;
    logic        fifo_pop;
    logic [4:0]  second_idx;
    logic        vblank;
    logic        head_ok;
    logic        second_ok;
    logic        wr_en;
    field_t      fld;
    logic [10:0] wr_field;

`ifdef CAR_WR_VBLANK_GATE_EN
    localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
    assign vblank = (y >= V_ACT);
`else
    logic unused_y;
    assign unused_y = ^y;
    assign vblank   = 1'b1;
`endif

    assign cmd_in = '{idx: bus.cmd_idx, x: bus.cmd_x, y: bus.cmd_y, ctrl: bus.cmd_ctrl};

    // Ready reflects only the registered occupancy; a push on a full FIFO
    // still lands when the FIFO pops in the same cycle.
    assign bus.cmd_ready = !fifo_full;

    car_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (bus.cmd_valid),
        .din        (cmd_in),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head),
        .multi      (fifo_multi),
        .second_idx (second_idx)
    );

    assign head_ok   = (32'(head.idx) < 32'(NUM_CARS));
    assign second_ok = (32'(second_idx) < 32'(NUM_CARS));

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        err_idx   = 1'b0;
        wr_en     = 1'b0;
        fld       = FLD_X;
        wr_field  = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = WAIT_VB;
            end
            WAIT_VB: begin
                if (fifo_empty) begin
                    state_nxt = IDLE;
                end else if (!head_ok) begin
                    // Bad index: drop it without touching the slot.
                    fifo_pop  = 1'b1;
                    err_idx   = 1'b1;
                    state_nxt = IDLE;
                end else if (vblank) begin
                    state_nxt = WR_X;
                end
            end
            WR_X: begin
                wr_en     = 1'b1;
                fld       = FLD_X;
                wr_field  = head.x;
                state_nxt = WR_Y;
            end
            WR_Y: begin
                wr_en     = 1'b1;
                fld       = FLD_Y;
                wr_field  = head.y;
                state_nxt = WR_CTRL;
            end
            WR_CTRL: begin
                wr_en    = 1'b1;
                fld      = FLD_CTRL;
                wr_field = {7'b0, head.ctrl};
                fifo_pop = 1'b1;
                // Chain straight into the next car only when it is known good;
                // a bad next index goes through WAIT_VB to be flagged.
                if (fifo_multi && vblank && second_ok) state_nxt = WR_X;
                else                                   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.cs      = 1'b0;
        bus.write   = 1'b0;
        bus.addr    = '0;
        bus.wr_data = '0;
        if (wr_en) begin
            bus.cs                 = 1'b1;
            bus.write              = 1'b1;
            bus.addr[REG_BANK_BIT] = 1'b1;
            bus.addr[5:0]          = car_offset(head.idx, fld);
            bus.wr_data            = {21'b0, wr_field};
        end
    end

    assign busy = !fifo_empty || (state == WR_X) || (state == WR_Y) || (state == WR_CTRL);
endmodule

// File: tb/tb_car_slot_writer.sv
module tb_car_slot_writer;

`ifdef CAR_WR_VBLANK_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] y = '0;
    logic        busy;
    logic        err_idx;

    car_slot_writer_if bus_if ();

    car_slot_writer #(
        .FIFO_DEPTH (4),
        .NUM_CARS   (20),
        .V_ACTIVE   (480)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .y       (y),
        .bus     (bus_if),
        .busy    (busy),
        .err_idx (err_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  checks = 0;
    int  failures = 0;
    int  n_writes = 0;
    int  n_errs = 0;
    int  push_cyc = 0;
    bit  mon_en = 1'b0;
    wr_t exp_q[$];
    int  err_q[$];
    int  wr_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_car(input logic [13:0] a0, input logic [31:0] dx,
                              input logic [31:0] dy, input logic [31:0] dc);
        exp_q.push_back('{addr: a0,        data: dx});
        exp_q.push_back('{addr: a0 + 14'd1, data: dy});
        exp_q.push_back('{addr: a0 + 14'd2, data: dc});
    endtask

    task automatic push_cmd(input logic [4:0] idx, input logic [10:0] px,
                            input logic [10:0] py, input logic [3:0] pc);
        int n;
        bus_if.cmd_idx   = idx;
        bus_if.cmd_x     = px;
        bus_if.cmd_y     = py;
        bus_if.cmd_ctrl  = pc;
        bus_if.cmd_valid = 1'b1;
        n = 0;
        while (!bus_if.cmd_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) fail_now("push_ready");
        tick(1);
        push_cyc = cyc;
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_writes(input int target, input string name);
        int n;
        n = 0;
        while (n_writes < target && n < 100) begin
            tick(1);
            n++;
        end
        if (n_writes < target) fail_now(name);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick(1);
            n++;
        end
        if (busy) fail_now(name);
    endtask

    task automatic wait_addr(input logic [13:0] a, input string name);
        int n;
        n = 0;
        while (!(bus_if.cs && bus_if.addr == a) && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) fail_now(name);
    endtask

    // Monitor: compares every slot write against the scoreboard and checks
    // that the bus is quiet between writes.
    always @(negedge clk) begin
        wr_t e;
        if (mon_en) begin
            if (bus_if.cs) begin
                n_writes++;
                wr_cyc.push_back(cyc);
                check("cs_eq_write", {31'b0, bus_if.write}, 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=0x%0h/0x%0h required=none",
                             bus_if.addr, bus_if.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {18'b0, bus_if.addr}, {18'b0, e.addr});
                    check("wr_data", bus_if.wr_data, e.data);
                end
                if (bus_if.addr[5:0] % 6'd3 == 6'd1)
                    check("wr_x_in_vblank", {31'b0, (!GATE || y >= 11'd480)}, 32'd1);
            end else begin
                check("idle_bus_zero",
                      {31'b0, (bus_if.write === 1'b0 && bus_if.addr === 14'd0 &&
                               bus_if.wr_data === 32'd0)}, 32'd1);
            end
            if (err_idx) begin
                n_errs++;
                if (err_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_err_idx actual=1 required=0");
                end else begin
                    void'(err_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ebase;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_idx   = '0;
        bus_if.cmd_x     = '0;
        bus_if.cmd_y     = '0;
        bus_if.cmd_ctrl  = '0;
        reset_n = 1'b0;
        tick(1);
        mon_en = 1'b1;
        tick(2);

        // Reset state
        check("rst_cs",      {31'b0, bus_if.cs},        32'd0);
        check("rst_write",   {31'b0, bus_if.write},     32'd0);
        check("rst_addr",    {18'b0, bus_if.addr},      32'd0);
        check("rst_wr_data", bus_if.wr_data,            32'd0);
        check("rst_busy",    {31'b0, busy},             32'd0);
        check("rst_err_idx", {31'b0, err_idx},          32'd0);
        check("rst_ready",   {31'b0, bus_if.cmd_ready}, 32'd1);
        reset_n = 1'b1;
        tick(1);

        // Car 0 queued at y=479, released at y=480
        y = 11'd479;
        base = n_writes;
        expect_car(14'h2001, 32'd100, 32'd200, 32'd5);
        push_cmd(5'd0, 11'd100, 11'd200, 4'd5);
        tick(6);
        check("gate_hold_writes", n_writes - base, GATE ? 32'd0 : 32'd3);
        check("gate_hold_busy",   {31'b0, busy},   GATE ? 32'd1 : 32'd0);
        y = 11'd480;
        wait_writes(base + 3, "car0_writes");
        check("car0_gap1", wr_cyc[base+1] - wr_cyc[base], 32'd1);
        check("car0_gap2", wr_cyc[base+2] - wr_cyc[base+1], 32'd1);
        wait_idle("car0_idle");

        // Push-to-write latency from an empty FIFO
        base = n_writes;
        expect_car(14'h2004, 32'd7, 32'd8, 32'd9);
        push_cmd(5'd1, 11'd7, 11'd8, 4'd9);
        wait_writes(base + 3, "lat_writes");
        check("lat_min2", {31'b0, (wr_cyc[base] - push_cyc >= 2)}, 32'd1);
        wait_idle("lat_idle");

        // Cars 19 and 3 back to back in vblank: six consecutive writes
        base = n_writes;
        expect_car(14'h203A, 32'd11, 32'd22, 32'd3);
        expect_car(14'h200A, 32'd33, 32'd44, 32'd6);
        push_cmd(5'd19, 11'd11, 11'd22, 4'd3);
        push_cmd(5'd3,  11'd33, 11'd44, 4'd6);
        wait_writes(base + 6, "b2b_writes");
        for (int i = 1; i < 6; i++)
            check("b2b_gap", wr_cyc[base+i] - wr_cyc[base+i-1], 32'd1);
        wait_idle("b2b_idle");

        // Out-of-range index 25 is dropped with one err_idx pulse
        base  = n_writes;
        ebase = n_errs;
        err_q.push_back(25);
        push_cmd(5'd25, 11'd1, 11'd2, 4'd3);
        wait_idle("err_idle");
        check("err_pulses",  n_errs - ebase,   32'd1);
        check("err_writes",  n_writes - base,  32'd0);
        check("err_busy",    {31'b0, busy},    32'd0);
        check("err_drained", err_q.size(),     32'd0);

        // vblank ends during WR_X: car completes, next car waits for y=480
        y = 11'd524;
        base = n_writes;
        expect_car(14'h2004, 32'd1, 32'd2, 32'd3);
        expect_car(14'h2007, 32'd4, 32'd5, 32'd6);
        push_cmd(5'd1, 11'd1, 11'd2, 4'd3);
        push_cmd(5'd2, 11'd4, 11'd5, 4'd6);
        wait_addr(14'h2004, "atomic_wr_x");
        y = 11'd0;
        tick(8);
        check("atomic_writes", n_writes - base, GATE ? 32'd3 : 32'd6);
        y = 11'd480;
        wait_writes(base + 6, "atomic_resume");
        wait_idle("atomic_idle");

        // Fill FIFO outside vblank, then push while full on the pop cycle
        y = 11'd100;
        base = n_writes;
        expect_car(14'h200D, 32'd40, 32'd41, 32'd1);
        expect_car(14'h2010, 32'd50, 32'd51, 32'd2);
        expect_car(14'h2013, 32'd60, 32'd61, 32'd3);
        expect_car(14'h2016, 32'd70, 32'd71, 32'd4);
        expect_car(14'h2019, 32'd80, 32'd81, 32'd5);
        push_cmd(5'd4, 11'd40, 11'd41, 4'd1);
        push_cmd(5'd5, 11'd50, 11'd51, 4'd2);
        push_cmd(5'd6, 11'd60, 11'd61, 4'd3);
        push_cmd(5'd7, 11'd70, 11'd71, 4'd4);
        check("full_ready", {31'b0, bus_if.cmd_ready}, 32'd0);
        bus_if.cmd_idx   = 5'd8;
        bus_if.cmd_x     = 11'd80;
        bus_if.cmd_y     = 11'd81;
        bus_if.cmd_ctrl  = 4'd5;
        bus_if.cmd_valid = 1'b1;
        y = 11'd480;
        begin
            int n;
            n = 0;
            while (!(bus_if.cs && bus_if.addr[5:0] % 6'd3 == 6'd0) &&
                   !bus_if.cmd_ready && n < 50) begin
                tick(1);
                n++;
            end
            if (n >= 50) fail_now("full_pop_wait");
        end
        check("ready_at_pop", {31'b0, bus_if.cmd_ready}, 32'd0);
        tick(1);
        bus_if.cmd_valid = 1'b0;
        check("ready_after_pushpop", {31'b0, bus_if.cmd_ready}, 32'd0);
        wait_writes(base + 15, "full_writes");
        wait_idle("full_idle");

        // Reset during WR_Y aborts the car; ctrl is never written
        base = n_writes;
        exp_q.push_back('{addr: 14'h201F, data: 32'd10});
        exp_q.push_back('{addr: 14'h2020, data: 32'd20});
        push_cmd(5'd10, 11'd10, 11'd20, 4'd12);
        wait_addr(14'h2020, "abort_wr_y");
        reset_n = 1'b0;
        tick(1);
        check("abort_cs",      {31'b0, bus_if.cs},        32'd0);
        check("abort_write",   {31'b0, bus_if.write},     32'd0);
        check("abort_addr",    {18'b0, bus_if.addr},      32'd0);
        check("abort_wr_data", bus_if.wr_data,            32'd0);
        check("abort_busy",    {31'b0, busy},             32'd0);
        check("abort_err_idx", {31'b0, err_idx},          32'd0);
        check("abort_ready",   {31'b0, bus_if.cmd_ready}, 32'd1);
        tick(2);
        reset_n = 1'b1;
        tick(6);
        check("abort_writes", n_writes - base, 32'd2);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("err_queue_empty",  err_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
